// File: rtl/exu_lsu_pkg.sv
// exu_lsu_pkg: LSU state encodings, load-size codes and store lane alignment.
package exu_lsu_pkg;
  typedef enum logic [1:0] {S_IDLE, S_CMD, S_RSP, S_DONE} lsu_state_e;
  localparam logic [1:0] CIRNO_LSZ_B = 2'd0;
  localparam logic [1:0] CIRNO_LSZ_H = 2'd1;
  localparam logic [1:0] CIRNO_LSZ_W = 2'd2;
  // Store size is implied by how many byte lanes are enabled.
  function automatic logic [31:0] st_align(input logic [31:0] d, input logic [3:0] wen);
    int n;
    n = $countones(wen);
    return n == 1 ? {4{d[7:0]}} : n == 2 ? {2{d[15:0]}} : d;
  endfunction
endpackage

// File: rtl/exu_lsu_if.sv
// exu_lsu_if: AGU handshake plus data-memory bus seen by the LSU.
interface exu_lsu_if;
  logic        hs_ag4ls_val;
  logic        hs_ls4ag_rdy;
  logic [31:0] i_ls_adr;
  logic [31:0] i_ls_wdat;
  logic [3:0]  i_ls_wen;
  logic        i_ls_ren;
  logic [1:0]  i_ls_lsz;
  logic        i_ls_uns;
  logic [31:0] o_ls_rdat;
  logic        o_ls_done;
  logic        o_ls_err;
  logic        o_mem_cmd_val;
  logic        i_mem_cmd_rdy;
  logic [31:0] o_mem_adr;
  logic [31:0] o_mem_wdat;
  logic [3:0]  o_mem_wen;
  logic        o_mem_ren;
  logic        i_mem_rsp_val;
  logic [31:0] i_mem_rdat;
  modport slave (
    input  hs_ag4ls_val, i_ls_adr, i_ls_wdat, i_ls_wen, i_ls_ren, i_ls_lsz, i_ls_uns,
           i_mem_cmd_rdy, i_mem_rsp_val, i_mem_rdat,
    output hs_ls4ag_rdy, o_ls_rdat, o_ls_done, o_ls_err,
           o_mem_cmd_val, o_mem_adr, o_mem_wdat, o_mem_wen, o_mem_ren
  );
  modport master (
    output hs_ag4ls_val, i_ls_adr, i_ls_wdat, i_ls_wen, i_ls_ren, i_ls_lsz, i_ls_uns,
           i_mem_cmd_rdy, i_mem_rsp_val, i_mem_rdat,
    input  hs_ls4ag_rdy, o_ls_rdat, o_ls_done, o_ls_err,
           o_mem_cmd_val, o_mem_adr, o_mem_wdat, o_mem_wen, o_mem_ren
  );
endinterface

// File: rtl/exu_lsu_ldext.sv
// exu_lsu_ldext: select byte/half/word from a memory word and sign/zero-extend it.
import exu_lsu_pkg::*;
module exu_lsu_ldext (
  input  logic [31:0] rdat,
  input  logic [1:0]  adr,
  input  logic [1:0]  lsz,
  input  logic        uns,
  output logic [31:0] res
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = 8'(rdat >> {adr, 3'b000});
    h = adr[1] ? rdat[31:16] : rdat[15:0];
    res = lsz == CIRNO_LSZ_B ? {{24{~uns & b[7]}}, b} :
          lsz == CIRNO_LSZ_H ? {{16{~uns & h[15]}}, h} : rdat;
  end
endmodule

// File: rtl/exu_lsu.sv
// exu_lsu: execute-stage load/store responder driving a variable-latency D-memory bus.
// Define CIRNO_LSU_TMO_EN to enable the TMO_W-bit response timeout (o_ls_err).
import exu_lsu_pkg::*;
module exu_lsu #(
  parameter int TMO_W = 8
) (
  input logic      clk,
  input logic      rst,
  exu_lsu_if.slave ls
);
  lsu_state_e  state, nxt;
  logic [31:0] adr_q, wdat_q, rdat_q, ext;
  logic [3:0]  wen_q;
  logic [1:0]  lsz_q;
  logic        ren_q, uns_q, err_q, acc, tmo, tmo_hit;
  assign acc = ls.hs_ag4ls_val & (state == S_IDLE);
`ifdef CIRNO_LSU_TMO_EN
  logic [TMO_W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (rst || nxt != state) ? '0 : cnt + 1'b1;
  assign tmo = &cnt & (state == S_CMD || state == S_RSP);
`else
  localparam int unused_tmo_w = TMO_W;
  assign tmo = 1'b0;
`endif
  assign tmo_hit = tmo & ((state == S_CMD & ~ls.i_mem_cmd_rdy) | (state == S_RSP & ~ls.i_mem_rsp_val));
  always_ff @(posedge clk)
    state <= rst ? S_IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (acc) nxt = (|ls.i_ls_wen || ls.i_ls_ren) ? S_CMD : S_DONE;
      S_CMD:  if (ls.i_mem_cmd_rdy) nxt = |wen_q ? S_DONE : S_RSP;
              else if (tmo) nxt = S_DONE;
      S_RSP:  if (ls.i_mem_rsp_val || tmo) nxt = S_DONE;
      default: nxt = S_IDLE;
    endcase
  end
  always_comb begin
    ls.hs_ls4ag_rdy  = state == S_IDLE;
    ls.o_mem_cmd_val = state == S_CMD;
    ls.o_ls_done     = state == S_DONE;
    ls.o_ls_err      = err_q;
    ls.o_ls_rdat     = rdat_q;
    ls.o_mem_adr     = {adr_q[31:2], 2'b00};
    ls.o_mem_wdat    = wdat_q;
    ls.o_mem_wen     = wen_q;
    ls.o_mem_ren     = ren_q;
  end
  exu_lsu_ldext u_ldext (.rdat(ls.i_mem_rdat), .adr(adr_q[1:0]), .lsz(lsz_q), .uns(uns_q), .res(ext));
  // A request carrying both read and write enables is a store; ren is dropped at latch time.
  always_ff @(posedge clk) begin
    if (rst) begin
      adr_q  <= '0;
      wdat_q <= '0;
      wen_q  <= '0;
      ren_q  <= 1'b0;
      lsz_q  <= '0;
      uns_q  <= 1'b0;
      rdat_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (acc) begin
        adr_q  <= ls.i_ls_adr;
        wdat_q <= st_align(ls.i_ls_wdat, ls.i_ls_wen);
        wen_q  <= ls.i_ls_wen;
        ren_q  <= ls.i_ls_ren & ~|ls.i_ls_wen;
        lsz_q  <= ls.i_ls_lsz;
        uns_q  <= ls.i_ls_uns;
      end
      if (state == S_RSP && ls.i_mem_rsp_val) rdat_q <= ext;
      else if (tmo_hit) rdat_q <= '0;
      err_q <= tmo_hit;
    end
  end
endmodule

// File: tb/tb_exu_lsu.sv
// tb_exu_lsu: directed self-checking bench for exu_lsu.
module tb_exu_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  exu_lsu_if bus();
  exu_lsu #(.TMO_W(4)) dut (.clk(clk), .rst(rst), .ls(bus));
  always #5 clk = ~clk;
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic req(input logic [31:0] adr, input logic [31:0] wdat, input logic [3:0] wen,
                     input logic ren, input logic [1:0] lsz, input logic uns);
    bus.hs_ag4ls_val = 1'b1;
    bus.i_ls_adr = adr;
    bus.i_ls_wdat = wdat;
    bus.i_ls_wen = wen;
    bus.i_ls_ren = ren;
    bus.i_ls_lsz = lsz;
    bus.i_ls_uns = uns;
    step();
    bus.hs_ag4ls_val = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    total++; if (bus.hs_ls4ag_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b exp=1", bus.hs_ls4ag_rdy); end
    total++; if (bus.o_ls_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.o_ls_done); end
    total++; if (bus.o_mem_cmd_val !== 1'b0) begin bad++; $display("FAIL reset_cmd got=%b exp=0", bus.o_mem_cmd_val); end
    total++; if (bus.o_ls_rdat !== 32'h0) begin bad++; $display("FAIL reset_rdat got=%h exp=0", bus.o_ls_rdat); end
    total++; if (bus.o_ls_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.o_ls_err); end
    total++; if (bus.o_mem_adr !== 32'h0 || bus.o_mem_wen !== 4'h0) begin bad++; $display("FAIL reset_bus got=%h/%h exp=0/0", bus.o_mem_adr, bus.o_mem_wen); end
  endtask
  task automatic test_lb();
    bus.i_mem_cmd_rdy = 1'b1;
    bus.i_mem_rsp_val = 1'b1;
    bus.i_mem_rdat = 32'h80FF1234;
    req(32'h103, 32'h0, 4'h0, 1'b1, 2'd0, 1'b0);
    total++; if (bus.o_mem_cmd_val !== 1'b1 || bus.o_mem_ren !== 1'b1) begin bad++; $display("FAIL lb_cmd got=%b%b exp=11", bus.o_mem_cmd_val, bus.o_mem_ren); end
    total++; if (bus.o_mem_adr !== 32'h100) begin bad++; $display("FAIL lb_adr got=%h exp=100", bus.o_mem_adr); end
    total++; if (bus.hs_ls4ag_rdy !== 1'b0) begin bad++; $display("FAIL lb_busy got=%b exp=0", bus.hs_ls4ag_rdy); end
    step();
    total++; if (bus.o_ls_done !== 1'b0) begin bad++; $display("FAIL lb_early got=%b exp=0", bus.o_ls_done); end
    step();
    total++; if (bus.o_ls_done !== 1'b1) begin bad++; $display("FAIL lb_done got=%b exp=1", bus.o_ls_done); end
    total++; if (bus.o_ls_rdat !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_rdat got=%h exp=ffffff80", bus.o_ls_rdat); end
    step();
    total++; if (bus.o_ls_done !== 1'b0 || bus.hs_ls4ag_rdy !== 1'b1) begin bad++; $display("FAIL lb_idle got=%b%b exp=01", bus.o_ls_done, bus.hs_ls4ag_rdy); end
  endtask
  task automatic test_half();
    logic [31:0] exp [2];
    exp[0] = 32'h00009ABC;
    exp[1] = 32'hFFFF9ABC;
    bus.i_mem_rdat = 32'h9ABC5678;
    for (int i = 0; i < 2; i++) begin
      req(32'h102, 32'h0, 4'h0, 1'b1, 2'd1, i == 0);
      step(2);
      total++; if (bus.o_ls_done !== 1'b1 || bus.o_ls_rdat !== exp[i]) begin bad++; $display("FAIL half%0d got=%b/%h exp=1/%h", i, bus.o_ls_done, bus.o_ls_rdat, exp[i]); end
      step();
    end
  endtask
  task automatic test_sb();
    req(32'h201, 32'h000000A5, 4'b0010, 1'b0, 2'd0, 1'b0);
    total++; if (bus.o_mem_wdat !== 32'hA5A5A5A5) begin bad++; $display("FAIL sb_wdat got=%h exp=a5a5a5a5", bus.o_mem_wdat); end
    total++; if (bus.o_mem_wen !== 4'b0010 || bus.o_mem_ren !== 1'b0) begin bad++; $display("FAIL sb_en got=%b/%b exp=0010/0", bus.o_mem_wen, bus.o_mem_ren); end
    total++; if (bus.o_mem_adr !== 32'h200) begin bad++; $display("FAIL sb_adr got=%h exp=200", bus.o_mem_adr); end
    step();
    total++; if (bus.o_ls_done !== 1'b1) begin bad++; $display("FAIL sb_done got=%b exp=1", bus.o_ls_done); end
    total++; if (bus.o_ls_rdat !== 32'hFFFF9ABC) begin bad++; $display("FAIL sb_rdat_hold got=%h exp=ffff9abc", bus.o_ls_rdat); end
    step();
    req(32'h002, 32'h0000BEEF, 4'b1100, 1'b0, 2'd0, 1'b0);
    total++; if (bus.o_mem_wdat !== 32'hBEEFBEEF) begin bad++; $display("FAIL sh_wdat got=%h exp=beefbeef", bus.o_mem_wdat); end
    step(2);
  endtask
  task automatic test_illegal();
    req(32'h300, 32'h11223344, 4'hF, 1'b1, 2'd2, 1'b0);
    total++; if (bus.o_mem_wdat !== 32'h11223344 || bus.o_mem_ren !== 1'b0 || bus.o_mem_wen !== 4'hF) begin bad++; $display("FAIL ill_cmd got=%h/%b/%h exp=11223344/0/f", bus.o_mem_wdat, bus.o_mem_ren, bus.o_mem_wen); end
    step();
    total++; if (bus.o_ls_done !== 1'b1) begin bad++; $display("FAIL ill_done got=%b exp=1", bus.o_ls_done); end
    step();
  endtask
  task automatic test_nop();
    req(32'h400, 32'h0, 4'h0, 1'b0, 2'd0, 1'b0);
    total++; if (bus.o_ls_done !== 1'b1 || bus.o_mem_cmd_val !== 1'b0) begin bad++; $display("FAIL nop got=%b%b exp=10", bus.o_ls_done, bus.o_mem_cmd_val); end
    step();
    total++; if (bus.o_ls_done !== 1'b0 || bus.hs_ls4ag_rdy !== 1'b1) begin bad++; $display("FAIL nop_idle got=%b%b exp=01", bus.o_ls_done, bus.hs_ls4ag_rdy); end
  endtask
  task automatic test_stall();
    int dones;
    dones = 0;
    bus.i_mem_cmd_rdy = 1'b0;
    bus.i_mem_rsp_val = 1'b1;
    bus.i_mem_rdat = 32'hCAFEF00D;
    req(32'h1004, 32'h0, 4'h0, 1'b1, 2'd2, 1'b0);
    bus.i_ls_adr = 32'hDEAD0000;
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.o_mem_cmd_val !== 1'b1 || bus.o_mem_adr !== 32'h1004 || bus.o_mem_ren !== 1'b1 || bus.hs_ls4ag_rdy !== 1'b0) begin bad++; $display("FAIL stall_cmd%0d got=%b/%h/%b/%b exp=1/1004/1/0", i, bus.o_mem_cmd_val, bus.o_mem_adr, bus.o_mem_ren, bus.hs_ls4ag_rdy); end
      step();
    end
    bus.i_mem_cmd_rdy = 1'b1;
    bus.i_mem_rsp_val = 1'b0;
    step();
    bus.i_mem_cmd_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.o_ls_done !== 1'b0 || bus.hs_ls4ag_rdy !== 1'b0 || bus.o_mem_cmd_val !== 1'b0) begin bad++; $display("FAIL stall_rsp%0d got=%b%b%b exp=000", i, bus.o_ls_done, bus.hs_ls4ag_rdy, bus.o_mem_cmd_val); end
      step();
    end
    bus.i_mem_rsp_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.o_ls_done === 1'b1) dones++;
    end
    bus.i_mem_rsp_val = 1'b0;
    total++; if (dones !== 1) begin bad++; $display("FAIL stall_dones got=%0d exp=1", dones); end
    total++; if (bus.o_ls_rdat !== 32'hCAFEF00D || bus.hs_ls4ag_rdy !== 1'b1) begin bad++; $display("FAIL stall_rdat got=%h/%b exp=cafef00d/1", bus.o_ls_rdat, bus.hs_ls4ag_rdy); end
  endtask
  task automatic test_reset_mid();
    bus.i_mem_cmd_rdy = 1'b1;
    bus.i_mem_rsp_val = 1'b0;
    req(32'h8, 32'h0, 4'h0, 1'b1, 2'd2, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (bus.hs_ls4ag_rdy !== 1'b1 || bus.o_ls_done !== 1'b0 || bus.o_mem_cmd_val !== 1'b0) begin bad++; $display("FAIL rstmid got=%b%b%b exp=100", bus.hs_ls4ag_rdy, bus.o_ls_done, bus.o_mem_cmd_val); end
    total++; if (bus.o_ls_rdat !== 32'h0) begin bad++; $display("FAIL rstmid_rdat got=%h exp=0", bus.o_ls_rdat); end
    bus.i_mem_rsp_val = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (bus.o_ls_done !== 1'b0 || bus.hs_ls4ag_rdy !== 1'b1) begin bad++; $display("FAIL rstmid_late%0d got=%b%b exp=01", i, bus.o_ls_done, bus.hs_ls4ag_rdy); end
    end
    bus.i_mem_rsp_val = 1'b0;
  endtask
  task automatic test_hang();
    int early;
    early = 0;
    bus.i_mem_cmd_rdy = 1'b1;
    bus.i_mem_rsp_val = 1'b0;
    bus.i_mem_rdat = 32'h55555555;
    req(32'h40, 32'h0, 4'h0, 1'b1, 2'd2, 1'b0);
`ifdef CIRNO_LSU_TMO_EN
    for (int i = 0; i < 16; i++) begin
      step();
      if (bus.o_ls_done !== 1'b0 || bus.o_ls_err !== 1'b0) early++;
    end
    total++; if (early !== 0) begin bad++; $display("FAIL tmo_early got=%0d exp=0", early); end
    step();
    total++; if (bus.o_ls_done !== 1'b1 || bus.o_ls_err !== 1'b1 || bus.o_ls_rdat !== 32'h0) begin bad++; $display("FAIL tmo got=%b%b/%h exp=11/0", bus.o_ls_done, bus.o_ls_err, bus.o_ls_rdat); end
    step();
`else
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.o_ls_done !== 1'b0 || bus.hs_ls4ag_rdy !== 1'b0 || bus.o_ls_err !== 1'b0) early++;
    end
    total++; if (early !== 0) begin bad++; $display("FAIL hang got=%0d bad cycles exp=0", early); end
    rst = 1'b1;
    step();
    rst = 1'b0;
`endif
    total++; if (bus.hs_ls4ag_rdy !== 1'b1) begin bad++; $display("FAIL hang_recover got=%b exp=1", bus.hs_ls4ag_rdy); end
  endtask
  initial begin
    bus.hs_ag4ls_val = 1'b0;
    bus.i_ls_adr = '0;
    bus.i_ls_wdat = '0;
    bus.i_ls_wen = '0;
    bus.i_ls_ren = 1'b0;
    bus.i_ls_lsz = '0;
    bus.i_ls_uns = 1'b0;
    bus.i_mem_cmd_rdy = 1'b0;
    bus.i_mem_rsp_val = 1'b0;
    bus.i_mem_rdat = '0;
    test_reset();
    test_lb();
    test_half();
    test_sb();
    test_illegal();
    test_nop();
    test_stall();
    test_reset_mid();
    test_hang();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/exu_lsu.md
Name: exu_lsu

Overview:
Load/store responder on the execute-stage LS handshake. Accepts one request per transaction from the AGU: registered valid, address, raw store data, byte-enables, read-enable. Performs lane alignment, drives a variable-latency data-memory bus and returns a sign/zero-extended load result plus a done pulse. Sits between the AGU and the D-memory/bus port.

Parameters:
TMO_W, 8, width of response-timeout counter (used only with CIRNO_LSU_TMO_EN)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
hs_ag4ls_val  in  1  request valid from AGU
hs_ls4ag_rdy  out  1  LSU can accept a request this cycle
i_ls_adr  in  32  byte address
i_ls_wdat  in  32  store data, unaligned (data in bits [7:0]/[15:0]/[31:0])
i_ls_wen  in  4  store byte-lane enables; nonzero means store
i_ls_ren  in  1  load request
i_ls_lsz  in  2  load size: 0 byte, 1 half, 2 word
i_ls_uns  in  1  load zero-extends (LBU/LHU)
o_ls_rdat  out  32  extended load result
o_ls_done  out  1  one-cycle pulse: transaction complete
o_mem_cmd_val  out  1  memory command valid
i_mem_cmd_rdy  in  1  memory command accepted
o_mem_adr  out  32  word-aligned address ({adr[31:2],2'b00})
o_mem_wdat  out  32  lane-aligned store data
o_mem_wen  out  4  byte enables to memory
o_mem_ren  out  1  read command
i_mem_rsp_val  in  1  memory response valid
i_mem_rdat  in  32  memory read word
o_ls_err  out  1  timeout error pulse (tied 0 without CIRNO_LSU_TMO_EN)

Behaviour:
- Reset (rst high at posedge): state IDLE; all outputs 0 except hs_ls4ag_rdy=1; latched request fields cleared. Reset mid-transaction abandons it; no done pulse.
- hs_ls4ag_rdy = (state==IDLE). Accept on hs_ag4ls_val & hs_ls4ag_rdy; latch adr[1:0], wen, ren, lsz, uns, aligned wdat.
- Request with ren=0 and wen=0: accepted, no bus command, o_ls_done pulses next cycle.
- ren and wen both nonzero: illegal; treated as store, ren ignored.
- Store alignment: byte -> wdat[7:0] replicated to all 4 lanes; half -> wdat[15:0] replicated to both halves; word unchanged. Size derived from popcount of wen.
- FSM: IDLE -> CMD on accept. CMD: o_mem_cmd_val=1, fields stable; advance on i_mem_cmd_rdy. Store -> DONE; load -> RSP. RSP: wait i_mem_rsp_val, capture i_mem_rdat, -> DONE. DONE: o_ls_done=1 for one cycle, -> IDLE.
- Min latency accept->done: store 2 cycles, load 3 cycles (rdy and rsp_val same-cycle as asserted).
- i_mem_rsp_val outside RSP ignored.
- Load extract: select byte adr[1:0] / half adr[1] / word; sign-extend from bit 7/15 unless uns. o_ls_rdat holds captured value until next load completes; stores leave it unchanged.
- Misaligned requests are not checked here (filtered upstream); half at adr[0]=1 uses adr[1] only.

Optional Feature:
CIRNO_LSU_TMO_EN: TMO_W-bit counter clears on entering CMD/RSP and increments each cycle in those states. At all-ones: o_ls_err pulses with o_ls_done, o_ls_rdat=0, FSM -> IDLE. Without macro: no counter, o_ls_err=0, waits indefinitely.

Decomposition:
- cirno9_define.v: LSU state encodings, load-size codes (CIRNO_LSZ_B/H/W).
- Sub-module lsu_ldext: combinational load extraction (rdat, adr[1:0], lsz, uns -> 32-bit result).
- dffr-style registers for state and latched fields.

Test Plan:
- LB adr=0x103, mem word 0x80FF1234, rdy/rsp immediate -> o_mem_adr=0x100, done at cycle 3, o_ls_rdat=0xFFFFFF80.
- LHU adr=0x102, mem 0x9ABC5678 -> o_ls_rdat=0x00009ABC; same with LH -> 0xFFFF9ABC.
- SB adr=0x201, wdat=0x000000A5, wen=4'b0010 -> o_mem_wdat=0xA5A5A5A5, wen=0010, ren=0, done 2 cycles after accept.
- Load with i_mem_cmd_rdy low 5 cycles, rsp 3 cycles later -> command fields stable throughout, hs_ls4ag_rdy=0 until done, single done pulse.
- rst asserted while in RSP -> next cycle IDLE, rdy=1, no done; late rsp_val ignored.
- CIRNO_LSU_TMO_EN, TMO_W=4, rsp never arrives -> o_ls_err and o_ls_done pulse after 15 RSP cycles, rdat=0; without macro FSM stays in RSP.
